// File: rtl/gpr_mp.sv
// gpr_mp: multi-port general-purpose register file with per-register busy scoreboard.
// Optional GPR_MP_BYPASS_EN forwards same-cycle writeback data to the read ports.
module gpr_mp #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG),
   parameter int NR   = 2,
   parameter int NW   = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NR*AW-1:0]   rd_addr,
   output logic [NR*XLEN-1:0] rd_data,
   output logic [NR-1:0]      rd_busy,
   input  logic [NW-1:0]      wr_valid,
   input  logic [NW*AW-1:0]   wr_addr,
   input  logic [NW*XLEN-1:0] wr_data,
   input  logic               iss_valid,
   input  logic [AW-1:0]      iss_rd,
   output logic [AW:0]        busy_cnt
);
   logic [XLEN-1:0] regs [NREG];
   logic [NREG-1:0] busy, busy_nxt;
   logic [AW:0]     dec;
   logic            inc;

   // clears first, then the issue set, so a new producer supersedes a same-cycle writeback
   always_comb begin
      busy_nxt = busy;
      for (int j = 0; j < NW; j++)
         if (wr_valid[j]) busy_nxt[wr_addr[j*AW +: AW]] = 1'b0;
      if (iss_valid) busy_nxt[iss_rd] = 1'b1;
      busy_nxt[0] = 1'b0;
      dec = '0;
      for (int r = 0; r < NREG; r++) dec = dec + (AW+1)'(busy[r] & ~busy_nxt[r]);
      inc = iss_valid && iss_rd != '0 && !busy[iss_rd];
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         for (int r = 0; r < NREG; r++) regs[r] <= '0;
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         for (int j = 0; j < NW; j++)
            if (wr_valid[j] && wr_addr[j*AW +: AW] != '0)
               regs[wr_addr[j*AW +: AW]] <= wr_data[j*XLEN +: XLEN];
         busy     <= busy_nxt;
         busy_cnt <= busy_cnt + (AW+1)'(inc) - dec;
      end

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [AW-1:0]   a;
      logic [XLEN-1:0] d;
      logic            b;
      assign a = rd_addr[i*AW +: AW];
      always_comb begin
         d = regs[a];
         b = busy[a];
`ifdef GPR_MP_BYPASS_EN
         for (int j = 0; j < NW; j++)
            if (wr_valid[j] && wr_addr[j*AW +: AW] == a) begin
               d = wr_data[j*XLEN +: XLEN];
               b = iss_valid && iss_rd == a;
            end
`endif
         if (!rst_n || a == '0) begin
            d = '0;
            b = 1'b0;
         end
      end
      assign rd_data[i*XLEN +: XLEN] = d;
      assign rd_busy[i]              = b;
   end
endmodule

// File: tb/tb_gpr_mp.sv
// tb_gpr_mp: scoreboard bench for gpr_mp; expected reads are queued at drive time
// from a behavioural register/busy model and popped when the DUT outputs are sampled.
module tb_gpr_mp;
   localparam int XLEN = 64, NREG = 32, AW = 5, NR = 2, NW = 2;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [NR*AW-1:0]   rd_addr = '0;
   logic [NR*XLEN-1:0] rd_data;
   logic [NR-1:0]      rd_busy;
   logic [NW-1:0]      wr_valid = '0;
   logic [NW*AW-1:0]   wr_addr = '0;
   logic [NW*XLEN-1:0] wr_data = '0;
   logic               iss_valid = 1'b0;
   logic [AW-1:0]      iss_rd = '0;
   logic [AW:0]        busy_cnt;

   gpr_mp #(.XLEN(XLEN), .NREG(NREG), .NR(NR), .NW(NW)) dut (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
      .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_cnt(busy_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string           tag;
      logic [XLEN-1:0] d0, d1;
      logic [1:0]      b;
      logic [AW:0]     cnt;
   } exp_t;

   exp_t            q[$];
   logic [XLEN-1:0] m_reg [NREG];
   logic [NREG-1:0] m_busy = '0;
   int              n_cmp = 0, n_bad = 0;

   task automatic check(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void exp_rd(input int i, output logic [XLEN-1:0] d, output logic b);
      logic [AW-1:0] a;
      a = rd_addr[i*AW +: AW];
      d = m_reg[a];
      b = m_busy[a];
`ifdef GPR_MP_BYPASS_EN
      for (int j = 0; j < NW; j++)
         if (wr_valid[j] && wr_addr[j*AW +: AW] == a) begin
            d = wr_data[j*XLEN +: XLEN];
            b = iss_valid && iss_rd == a;
         end
`endif
      if (!rst_n || a == '0) begin
         d = '0;
         b = 1'b0;
      end
   endfunction

   task automatic push_exp(input string tag);
      exp_t          e;
      logic [XLEN-1:0] d;
      logic          b;
      e.tag = tag;
      exp_rd(0, d, b);
      e.d0 = d; e.b[0] = b;
      exp_rd(1, d, b);
      e.d1 = d; e.b[1] = b;
      e.cnt = rst_n ? (AW+1)'($countones(m_busy)) : '0;
      q.push_back(e);
   endtask

   task automatic pop_cmp();
      exp_t e;
      if (q.size() == 0) begin
         check("queue_empty", 1, 0);
         return;
      end
      e = q.pop_front();
      check({e.tag, "_d0"}, rd_data[0 +: XLEN], e.d0);
      check({e.tag, "_d1"}, rd_data[XLEN +: XLEN], e.d1);
      check({e.tag, "_busy"}, XLEN'(rd_busy), XLEN'(e.b));
      check({e.tag, "_cnt"}, XLEN'(busy_cnt), XLEN'(e.cnt));
   endtask

   task automatic model_edge();
      for (int j = 0; j < NW; j++)
         if (wr_valid[j] && wr_addr[j*AW +: AW] != '0) begin
            m_reg[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
            m_busy[wr_addr[j*AW +: AW]] = 1'b0;
         end
      if (iss_valid && iss_rd != '0) m_busy[iss_rd] = 1'b1;
   endtask

   // called just after a posedge: drive, check at negedge, advance model at posedge
   task automatic cyc(input string tag, input logic [AW-1:0] r0, input logic [AW-1:0] r1,
                      input logic [NW-1:0] wv, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                      input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1,
                      input logic iv, input logic [AW-1:0] ir);
      rd_addr = {r1, r0};
      wr_valid = wv;
      wr_addr = {a1, a0};
      wr_data = {d1, d0};
      iss_valid = iv;
      iss_rd = ir;
      push_exp(tag);
      @(negedge clk);
      pop_cmp();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic idle_rd(input string tag, input logic [AW-1:0] r0, input logic [AW-1:0] r1);
      cyc(tag, r0, r1, 2'b00, '0, '0, '0, '0, 1'b0, '0);
   endtask

   initial begin
      for (int r = 0; r < NREG; r++) m_reg[r] = '0;
      #2;
      push_exp("in_reset");
      #1;
      pop_cmp();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      for (int a = 0; a < NREG; a++) idle_rd("reset_rd", AW'(a), AW'(NREG-1-a));

      cyc("wr_same", 5, 5, 2'b11, 5, 5, 64'h1111, 64'h2222, 1'b0, 0);
      idle_rd("prio_x5", 5, 0);
      cyc("wr_x0", 0, 5, 2'b01, 0, 0, 64'hDEAD, 0, 1'b0, 0);
      idle_rd("x0_zero", 0, 5);

      cyc("iss_x7", 7, 0, 2'b00, 0, 0, 0, 0, 1'b1, 7);
      idle_rd("busy_x7", 7, 7);
      cyc("wb_iss_x7", 7, 0, 2'b01, 7, 0, 64'h77, 0, 1'b1, 7);
      idle_rd("still_x7", 7, 0);
      cyc("wb_x7", 7, 0, 2'b10, 0, 7, 0, 64'h777, 1'b0, 0);
      idle_rd("free_x7", 7, 0);

      for (int r = 1; r < NREG; r++)
         cyc("iss_all", AW'(r), AW'(r-1), 2'b00, 0, 0, 0, 0, 1'b1, AW'(r));
      idle_rd("all_busy", 1, 31);
      for (int r = 1; r < NREG; r += 2)
         cyc("wb_all", AW'(r), AW'(r+1), 2'b11, AW'(r), AW'(r+1),
             {32'h0, $urandom}, {$urandom, 32'h0}, 1'b0, 0);
      idle_rd("none_busy", 9, 30);
      idle_rd("none_busy2", 31, 1);

      cyc("rw_x9", 9, 9, 2'b01, 9, 0, 64'hABCD, 0, 1'b0, 0);
      idle_rd("after_x9", 9, 0);

      cyc("wr_x3", 3, 4, 2'b01, 3, 0, 64'h55, 0, 1'b0, 0);
      cyc("iss_x4", 3, 4, 2'b00, 0, 0, 0, 0, 1'b1, 4);
      idle_rd("pre_rst", 3, 4);
      rd_addr = {AW'(4), AW'(3)};
      rst_n = 1'b0;
      for (int r = 0; r < NREG; r++) m_reg[r] = '0;
      m_busy = '0;
      push_exp("async_rst");
      #1;
      pop_cmp();
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idle_rd("post_rst", 3, 4);

      for (int k = 0; k < 300; k++) begin
         logic [AW-1:0] a0, a1;
         a0 = AW'($urandom_range(0, 7));
         a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 7));
         cyc("rand", AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
             NW'($urandom), a0, a1, {$urandom, $urandom}, {$urandom, $urandom},
             1'($urandom), AW'($urandom_range(0, 7)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/gpr_mp.md
Name: gpr_mp

Overview:
- Parametrised multi-port general-purpose register file: successor to the single-write, two-read core GPR.
- Adds:
  - configurable width, depth and read/write port counts;
  - per-register busy scoreboard, set at issue and cleared at writeback;
  - asynchronous reset of the architectural state.
- Sits between issue/EXU (read ports, issue port) and LSU/WB (write ports).

Parameters:
- XLEN, 64, register data width in bits.
- NREG, 32, number of architectural registers including hardwired-zero x0; power of two, at least 2.
- AW, $clog2(NREG), register address width.
- NR, 2, number of read ports.
- NW, 2, number of write ports; port index NW-1 has highest priority.

Ports:
- clk  input  1  core clock, all state updates on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- rd_addr  input  NR*AW  read addresses, port i at bits [i*AW +: AW].
- rd_data  output  NR*XLEN  read data, port i at bits [i*XLEN +: XLEN].
- rd_busy  output  NR  bit i = 1 when the register read on port i has an outstanding producer.
- wr_valid  input  NW  per-port writeback valid; already qualified with the destination-write-enable.
- wr_addr  input  NW*AW  writeback destination per port.
- wr_data  input  NW*XLEN  writeback data per port.
- iss_valid  input  1  an instruction with a destination register is issued this cycle.
- iss_rd  input  AW  destination register of the issued instruction.
- busy_cnt  output  AW+1  number of registers currently marked busy.

Behaviour:
- Reset (rst_n low, async):
  - all registers 1..NREG-1 = 0; all busy bits = 0; busy_cnt = 0.
  - rd_data is combinational and reads 0 during reset; rd_busy = 0.
- Writes:
  - Register r is written at posedge when any port j has wr_valid[j] and wr_addr[j] == r, with r != 0.
  - Several ports writing the same r in one cycle: the highest port index wins.
  - Writes to x0 are dropped: no data change, no busy change.
- Reads:
  - Combinational, zero latency.
  - rd_addr == 0 -> rd_data = 0 and rd_busy = 0.
  - Without the bypass, a read in the same cycle as a write returns the old value; the new value is visible from the next cycle.
- Scoreboard (1 bit per register, x0 is never busy):
  - At posedge, iss_valid with iss_rd != 0 sets busy[iss_rd].
  - At posedge, wr_valid[j] with wr_addr[j] != 0 clears busy[wr_addr[j]].
  - Set and clear on the same register in the same cycle: set wins, because the new producer supersedes the old one.
  - A clear on a non-busy register is legal and has no effect.
  - Issue on an already-busy register keeps it busy (WAW); the first writeback then clears it. Issue must stall WAW hazards upstream; this block does not track multiple producers.
- busy_cnt:
  - Registered; equals the popcount of the busy vector after each posedge.
  - Updated incrementally: +1 per 0->1 transition, -1 per 1->0 transition.
  - Range 0..NREG-1, can never wrap.
- rst_n asserted mid-operation: all state is cleared immediately; pending issues are lost.

Optional Feature:
- Macro: GPR_MP_BYPASS_EN.
- Defined:
  - Each read port forwards same-cycle write data. If any wr_valid[j] has wr_addr[j] == rd_addr[i] != 0, rd_data[i] = wr_data of the highest such j.
  - rd_busy[i] is forced to 0 for that port, unless iss_valid && iss_rd == rd_addr[i] in the same cycle.
- Undefined: no forwarding. Reads see the register array only, and rd_busy reflects the registered busy bit only.

Test Plan:
- Reset, then read addresses 0..31 on both ports -> every rd_data = 0, rd_busy = 0, busy_cnt = 0.
- wr_valid = 2'b11 with both ports targeting x5 (port0 = 0x1111, port1 = 0x2222); next cycle read x5 -> 0x2222. Separately, write 0xDEAD to x0 -> x0 still reads 0.
- Scoreboard:
  - Issue x7 -> next cycle rd_busy = 1, busy_cnt = 1.
  - In one cycle, writeback x7 plus issue x7 -> still busy, busy_cnt = 1.
  - Writeback x7 alone -> busy 0, busy_cnt = 0.
- Issue x1..x31 on consecutive cycles -> busy_cnt = 31; all of them written back two per cycle -> busy_cnt reaches 0 with no underflow.
- Read x9 while writing 0xABCD to x9 in the same cycle:
  - GPR_MP_BYPASS_EN defined -> rd_data = 0xABCD in that cycle.
  - Undefined -> old value that cycle, 0xABCD the next cycle.
- Write x3 = 0x55, issue x4, then pulse rst_n low between clock edges -> x3 reads 0 and busy_cnt = 0 immediately, without waiting for a clock edge.
